// File: rtl/register_file.sv
// Two-read, one-write register file with hard-wired zero register.
// Define REGFILE_WRITE_BYPASS_EN to forward write data onto matching reads.
module register_file #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32,
  localparam int AW      = $clog2(NUM_REGS)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              WE3,
  input  logic [AW-1:0]     i_A1_addr,
  input  logic [AW-1:0]     i_A2_addr,
  input  logic [AW-1:0]     i_A3_addr,
  input  logic [DATA_W-1:0] i_WD3_data,
  output logic [DATA_W-1:0] o_RD1,
  output logic [DATA_W-1:0] o_RD2
);

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic              wr_en;

  assign wr_en = WE3 && (i_A3_addr != '0);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en) begin
      regs[i_A3_addr] <= i_WD3_data;
    end
  end

  // Entry 0 is never written, but reads of it are masked anyway.
  function automatic logic [DATA_W-1:0] rd_port(
    input logic [AW-1:0] addr
  );
    logic [DATA_W-1:0] val;
    val = '0;
    if (addr != '0 && int'(addr) < NUM_REGS) begin
`ifdef REGFILE_WRITE_BYPASS_EN
      if (wr_en && !i_rst && addr == i_A3_addr) begin
        val = i_WD3_data;
      end else begin
        val = regs[addr];
      end
`else
      val = regs[addr];
`endif
    end
    return val;
  endfunction

  always_comb begin
    o_RD1 = rd_port(i_A1_addr);
  end

  always_comb begin
    o_RD2 = rd_port(i_A2_addr);
  end

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: vector table, corner
// sequences and a randomized run against an array reference model.
module tb_register_file;

  logic        i_clk;
  logic        i_rst;
  logic        WE3;
  logic [4:0]  i_A1_addr;
  logic [4:0]  i_A2_addr;
  logic [4:0]  i_A3_addr;
  logic [31:0] i_WD3_data;
  logic [31:0] o_RD1;
  logic [31:0] o_RD2;

  int errors = 0;
  int checks = 0;

`ifdef REGFILE_WRITE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  register_file dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .WE3        (WE3),
    .i_A1_addr  (i_A1_addr),
    .i_A2_addr  (i_A2_addr),
    .i_A3_addr  (i_A3_addr),
    .i_WD3_data (i_WD3_data),
    .o_RD1      (o_RD1),
    .o_RD2      (o_RD2)
  );

  initial i_clk = 1'b0;
  always #50 i_clk = ~i_clk;

  typedef struct {
    logic        we;
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic [4:0]  a3;
    logic [31:0] wd;
    logic [31:0] exp1;
    logic [31:0] exp2;
  } vec_t;

  vec_t        vecs [6];
  logic [31:0] model [32];

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  function automatic logic [31:0] expect_rd(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (BYP && WE3 && a == i_A3_addr) return i_WD3_data;
    return model[a];
  endfunction

  initial begin
    i_rst      = 1'b1;
    WE3        = 1'b0;
    i_A1_addr  = '0;
    i_A2_addr  = '0;
    i_A3_addr  = '0;
    i_WD3_data = '0;

    #20;
    check("reset_rd1", o_RD1, 32'd0);
    check("reset_rd2", o_RD2, 32'd0);
    i_rst = 1'b0;

    // Zero register with all inputs idle
    #1;
    check("zero_pre_rd1", o_RD1, 32'd0);
    check("zero_pre_rd2", o_RD2, 32'd0);
    tick();
    tick();
    check("zero_post_rd1", o_RD1, 32'd0);
    check("zero_post_rd2", o_RD2, 32'd0);

    // Table: reads checked before the edge that commits the write
    vecs[0] = '{1'b1, 5'd0, 5'd0, 5'd5, 32'd5,        32'd0,    32'd0};
    vecs[1] = '{1'b0, 5'd5, 5'd5, 5'd5, 32'hFFFFFFFF, 32'd5,    32'd5};
    vecs[2] = '{1'b1, 5'd5, 5'd0, 5'd0, 32'hDEADBEEF, 32'd5,    32'd0};
    vecs[3] = '{1'b0, 5'd0, 5'd5, 5'd0, 32'd0,        32'd0,    32'd5};
    vecs[4] = '{1'b1, 5'd5, 5'd3, 5'd9, 32'h0000A5A5, 32'd5,    32'd0};
    vecs[5] = '{1'b0, 5'd9, 5'd9, 5'd1, 32'd1,        32'hA5A5, 32'hA5A5};
    for (int v = 0; v < 6; v++) begin
      WE3        = vecs[v].we;
      i_A1_addr  = vecs[v].a1;
      i_A2_addr  = vecs[v].a2;
      i_A3_addr  = vecs[v].a3;
      i_WD3_data = vecs[v].wd;
      #1;
      check($sformatf("vec%0d_rd1", v), o_RD1, vecs[v].exp1);
      check($sformatf("vec%0d_rd2", v), o_RD2, vecs[v].exp2);
      tick();
    end

    // Fill x[n] = n
    for (int n = 1; n < 32; n++) begin
      WE3        = 1'b1;
      i_A3_addr  = 5'(n);
      i_WD3_data = 32'(n);
      tick();
    end
    WE3       = 1'b0;
    i_A1_addr = 5'd30;
    i_A2_addr = 5'd31;
    #1;
    check("fill_rd1_x30", o_RD1, 32'd30);
    check("fill_rd2_x31", o_RD2, 32'd31);
    for (int n = 1; n < 32; n++) begin
      i_A1_addr = 5'(n);
      i_A2_addr = 5'(32 - n);
      #1;
      check($sformatf("fill_rd1_x%0d", n), o_RD1, 32'(n));
      check($sformatf("fill_rd2_x%0d", 32 - n), o_RD2, 32'(32 - n));
    end

    // x0 write protection
    WE3        = 1'b1;
    i_A3_addr  = 5'd0;
    i_WD3_data = 32'hDEADBEEF;
    tick();
    WE3       = 1'b0;
    i_A1_addr = 5'd0;
    #1;
    check("x0_protect", o_RD1, 32'd0);

    // Write enable low leaves x5 alone
    i_A3_addr  = 5'd5;
    i_WD3_data = 32'hFFFFFFFF;
    tick();
    i_A1_addr = 5'd5;
    #1;
    check("we_low_x5", o_RD1, 32'd5);

    // Same-address read/write
    i_A1_addr  = 5'd7;
    i_A3_addr  = 5'd7;
    i_WD3_data = 32'h1234;
    WE3        = 1'b1;
    #1;
    check("same_addr_pre", o_RD1, BYP ? 32'h1234 : 32'd7);
    tick();
    WE3 = 1'b0;
    #1;
    check("same_addr_post", o_RD1, 32'h1234);

    // Async reset mid-cycle, no clock edge
    tick();
    #5;
    i_rst = 1'b1;
    #1;
    for (int n = 1; n < 32; n++) begin
      i_A1_addr = 5'(n);
      i_A2_addr = 5'(n);
      #1;
      check($sformatf("async_rst_x%0d", n), o_RD1, 32'd0);
    end
    check("async_rst_rd2", o_RD2, 32'd0);

    // Write at an edge while reset is held is lost
    WE3        = 1'b1;
    i_A3_addr  = 5'd4;
    i_WD3_data = 32'h77;
    i_A1_addr  = 5'd4;
    #1;
    check("rst_bypass_blocked", o_RD1, 32'd0);
    tick();
    i_rst = 1'b0;
    WE3   = 1'b0;
    #1;
    check("rst_write_lost", o_RD1, 32'd0);

    // First write after reset release
    WE3 = 1'b1;
    tick();
    WE3 = 1'b0;
    #1;
    check("post_rst_write", o_RD1, 32'h77);

    // Randomized run against the array model
    for (int i = 0; i < 32; i++) model[i] = 32'd0;
    model[4] = 32'h77;
    for (int it = 0; it < 400; it++) begin
      WE3        = 1'($urandom_range(0, 1));
      i_A1_addr  = 5'($urandom_range(0, 31));
      i_A2_addr  = ($urandom_range(0, 3) == 0) ? i_A1_addr
                                               : 5'($urandom_range(0, 31));
      i_A3_addr  = ($urandom_range(0, 3) == 0) ? i_A1_addr
                                               : 5'($urandom_range(0, 31));
      i_WD3_data = $urandom;
      #1;
      check($sformatf("rnd%0d_rd1", it), o_RD1, expect_rd(i_A1_addr));
      check($sformatf("rnd%0d_rd2", it), o_RD2, expect_rd(i_A2_addr));
      if ($urandom_range(0, 39) == 0) begin
        #2;
        i_rst = 1'b1;
        #2;
        check($sformatf("rnd%0d_rst", it), o_RD1, 32'd0);
        i_rst = 1'b0;
        for (int i = 0; i < 32; i++) model[i] = 32'd0;
      end
      tick();
      if (WE3 && i_A3_addr != 5'd0) model[i_A3_addr] = i_WD3_data;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
